histo_deserializer: RTL and testbench
=====================================

Name: histo_deserializer

Overview:
Receive-side counterpart of the histogram serial link. Oversamples a SPI mode 0 stream (SCLK + MOSI only, no chip select) on fast_clk_in. Rebuilds 32-bit histogram words sent as four bytes, least-significant byte first and MSB-first within each byte. Presents each word on a one-deep valid/ready output with overrun and framing flags. Sits at the aggregator/bridge end of the camera histogram link.

Parameters:
IDLE_TIMEOUT, 256, fast_clk_in cycles of SCLK held low before bit and byte counters are realigned; range 8..65535.
SYNC_STAGES, 2, synchronizer flops on serial_clk_in and serial_in; range 2..3.

Ports:
fast_clk_in  in  1  system clock; at least 8x the SCLK rate
reset  in  1  synchronous, active-high
serial_clk_in  in  1  link SCLK, asynchronous to fast_clk_in; idles low
serial_in  in  1  link MOSI data
resync  in  1  single-cycle pulse; discards partial byte and word, next bit is bit 7 of byte 0
clear_errors  in  1  single-cycle pulse; clears sticky flags
m_data  out  32  assembled word
m_valid  out  1  m_data holds an unconsumed word
m_ready  in  1  consumer accepts m_data when m_valid and m_ready are both high
overrun  out  1  sticky; a word completed while the holding register was full
frame_error  out  1  sticky; timeout or resync hit a partially received byte
byte_index  out  2  index of the byte currently being received (debug)

Behaviour:
- Reset is synchronous, active-high, clock fast_clk_in. On reset: m_data=0, m_valid=0, overrun=0, frame_error=0, byte_index=0, bit counter=0, idle counter=0, synchronizer flops=0.
- Synchronization: serial_clk_in and serial_in each pass through SYNC_STAGES flops. A rising edge is detected when the last synchronized SCLK stage is 1 and its registered copy is 0. MOSI is sampled from the same synchronized stage in that same cycle (mode 0).
- Shift: on each rise, shift the sample into an 8-bit shift register, MSB first, and increment the 3-bit bit counter.
- Byte complete (bit counter wraps 7->0): write the byte to word[8*byte_index+7 : 8*byte_index], then increment byte_index, wrapping 3->0.
- Word complete (byte 3 done): load the holding register.
- Latency: m_valid rises SYNC_STAGES+2 fast_clk_in cycles after the first fast_clk_in edge that samples serial_clk_in high for bit 0 of byte 3. That is 4 cycles at the default.
- Holding register and handshake:
  - m_valid goes high when a word completes.
  - m_valid goes low on the cycle after m_valid && m_ready, unless a new word completes in that same cycle.
  - If a word completes while m_valid=1 and m_ready=0: drop the new word, keep m_data unchanged, set overrun.
  - If a word completes while m_valid=1 and m_ready=1: accept the old word, load the new one, keep m_valid=1, no overrun.
  - m_data is stable while m_valid=1 and m_ready=0.
- Idle counter:
  - Counts cycles with synchronized SCLK low; any SCLK high sample clears it.
  - It saturates, and when it reaches IDLE_TIMEOUT the bit counter and byte_index are cleared.
  - If the bit counter was non-zero at that point, set frame_error.
  - A timeout with bit counter=0 and byte_index non-zero (1-3 whole bytes received) also sets frame_error and discards those bytes.
  - A timeout with both counters at 0 is a silent realign.
- resync: same effect as a timeout, including the frame_error rule, applied in the cycle it is seen. If resync and a rise arrive in the same cycle, resync wins and the bit is dropped.
- clear_errors: clears overrun and frame_error. If it coincides with a new error event, the set wins.
- Inter-byte gaps in the link are far shorter than IDLE_TIMEOUT, so words must assemble across them without realignment. Word alignment at power-up depends on the first idle period or on resync.
- SCLK high or low for fewer than 2 fast_clk_in cycles is out of spec; no detection is required.

Decomposition:
- Shared package histo_link_pkg holds:
  - HISTO_WORD_BYTES=4
  - HISTO_BYTE_BITS=8
  - HISTO_WORD_BITS=32
  - the byte-order convention (LSB byte first, MSB bit first).
- The package is shared with the transmit serializer.
- One natural sub-module, histo_link_sync: SYNC_STAGES synchronizer for SCLK/MOSI plus the registered rise-detect strobe and the aligned data sample.

Test Plan:
- After reset and 300 idle cycles, send bytes 0x11,0x22,0x33,0x44 at 16 fast clocks per half-bit, m_ready=1 -> one m_valid pulse with m_data=0x44332211; overrun=0, frame_error=0.
- Two back-to-back words 0xDEADBEEF then 0x01234567, 40-cycle inter-byte gaps, m_ready=1 -> two m_valid pulses in order with those values; byte_index returns to 0.
- m_ready=0 while words 0xAAAA5555 and 0x12345678 are sent -> m_data stays 0xAAAA5555, overrun=1. Then m_ready=1 for one cycle -> m_valid=0. clear_errors -> overrun=0.
- Send 5 bits, idle 300 cycles, then word 0xCAFEF00D -> frame_error=1 and m_data=0xCAFEF00D (clean realign after the timeout).
- Send 2 bytes, pulse resync, send word 0x0F0F0F0F -> frame_error=1, m_data=0x0F0F0F0F. Assert reset mid-byte -> all outputs 0 and next word is received correctly.

Source files
------------

// File: rtl/histo_link_pkg.sv
// Shared definitions for the histogram serial link (serializer and deserializer).
// Bytes travel least-significant byte first, most-significant bit first within each byte.
package histo_link_pkg;

    localparam int unsigned HISTO_WORD_BYTES = 4;
    localparam int unsigned HISTO_BYTE_BITS  = 8;
    localparam int unsigned HISTO_WORD_BITS  = 32;

    typedef logic [HISTO_BYTE_BITS-1:0] histo_byte_t;
    typedef logic [HISTO_WORD_BITS-1:0] histo_word_t;

    // Byte lane idx occupies word bits [8*idx+7 : 8*idx].
    function automatic histo_word_t histo_put_byte(input histo_word_t word,
                                                   input logic [1:0]  idx,
                                                   input histo_byte_t data);
        histo_word_t res;
        res = word;
        res[{idx, 3'b000} +: HISTO_BYTE_BITS] = data;
        return res;
    endfunction

endpackage

// File: rtl/histo_link_sync.sv
// SCLK/MOSI synchronizer with a registered SCLK rise strobe and the MOSI sample
// aligned to it (mode 0: data is taken at the rising edge).
module histo_link_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic fast_clk_in,
    input  logic reset,
    input  logic serial_clk_in,
    input  logic serial_in,
    output logic sclk_level,
    output logic rise,
    output logic rise_data
);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   rise_q, rise_d;
    logic                   data_q, data_d;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], serial_clk_in};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], serial_in};
        sclk_prev_d = sclk_sync_q[SYNC_STAGES-1];
        rise_d      = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
        data_d      = mosi_sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge fast_clk_in) begin
        if (reset) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            rise_q      <= 1'b0;
            data_q      <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            rise_q      <= rise_d;
            data_q      <= data_d;
        end
    end

    assign sclk_level = sclk_sync_q[SYNC_STAGES-1];
    assign rise       = rise_q;
    assign rise_data  = data_q;

endmodule

// File: rtl/histo_deserializer.sv
// Receive end of the histogram link: rebuilds 32-bit words from an oversampled
// SPI mode 0 stream and presents them on a one-deep valid/ready holding register.
module histo_deserializer
    import histo_link_pkg::*;
#(
    parameter int unsigned IDLE_TIMEOUT = 256,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                       fast_clk_in,
    input  logic                       reset,
    input  logic                       serial_clk_in,
    input  logic                       serial_in,
    input  logic                       resync,
    input  logic                       clear_errors,
    output logic [HISTO_WORD_BITS-1:0] m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       overrun,
    output logic                       frame_error,
    output logic [1:0]                 byte_index
);

    localparam int unsigned IDLE_W = 16;
    localparam int unsigned BIT_W  = $clog2(HISTO_BYTE_BITS);
    localparam int unsigned IDX_W  = $clog2(HISTO_WORD_BYTES);

    logic sclk_level, rise, rise_data;

    histo_link_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .fast_clk_in   (fast_clk_in),
        .reset         (reset),
        .serial_clk_in (serial_clk_in),
        .serial_in     (serial_in),
        .sclk_level    (sclk_level),
        .rise          (rise),
        .rise_data     (rise_data)
    );

    logic [IDLE_W-1:0]          idle_q, idle_d;
    logic [BIT_W-1:0]           bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]           byte_idx_q, byte_idx_d;
    logic [HISTO_BYTE_BITS-2:0] shift_q, shift_d;
    histo_word_t                word_q, word_d;
    logic                       word_done_q, word_done_d;
    histo_word_t                m_data_q, m_data_d;
    logic                       m_valid_q, m_valid_d;
    logic                       overrun_q, overrun_d;
    logic                       frame_error_q, frame_error_d;
    logic                       timeout, realign, frame_set, overrun_set;
    histo_byte_t                rx_byte;

    // Bit/byte assembly; a realign (timeout or resync) beats a coincident rise.
    always_comb begin
        idle_d      = idle_q;
        bit_cnt_d   = bit_cnt_q;
        byte_idx_d  = byte_idx_q;
        shift_d     = shift_q;
        word_d      = word_q;
        word_done_d = 1'b0;
        frame_set   = 1'b0;
        rx_byte     = {shift_q, rise_data};

        timeout = (idle_q == IDLE_W'(IDLE_TIMEOUT));
        realign = resync | timeout;

        if (sclk_level) begin
            idle_d = '0;
        end else if (!timeout) begin
            idle_d = idle_q + IDLE_W'(1);
        end

        if (realign) begin
            frame_set  = (bit_cnt_q != '0) || (byte_idx_q != '0);
            bit_cnt_d  = '0;
            byte_idx_d = '0;
        end else if (rise) begin
            shift_d   = rx_byte[HISTO_BYTE_BITS-2:0];
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == BIT_W'(HISTO_BYTE_BITS - 1)) begin
                word_d      = histo_put_byte(word_q, byte_idx_q, rx_byte);
                byte_idx_d  = byte_idx_q + IDX_W'(1);
                word_done_d = (byte_idx_q == IDX_W'(HISTO_WORD_BYTES - 1));
            end
        end
    end

    // Holding register, handshake and sticky flags (a new error beats clear_errors).
    always_comb begin
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        overrun_set = 1'b0;

        if (word_done_q) begin
            if (!m_valid_q || m_ready) begin
                m_data_d  = word_q;
                m_valid_d = 1'b1;
            end else begin
                overrun_set = 1'b1;
            end
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        overrun_d     = (overrun_q & ~clear_errors) | overrun_set;
        frame_error_d = (frame_error_q & ~clear_errors) | frame_set;
    end

    always_ff @(posedge fast_clk_in) begin
        if (reset) begin
            idle_q        <= '0;
            bit_cnt_q     <= '0;
            byte_idx_q    <= '0;
            shift_q       <= '0;
            word_q        <= '0;
            word_done_q   <= 1'b0;
            m_data_q      <= '0;
            m_valid_q     <= 1'b0;
            overrun_q     <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            idle_q        <= idle_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_idx_q    <= byte_idx_d;
            shift_q       <= shift_d;
            word_q        <= word_d;
            word_done_q   <= word_done_d;
            m_data_q      <= m_data_d;
            m_valid_q     <= m_valid_d;
            overrun_q     <= overrun_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign m_data      = m_data_q;
    assign m_valid     = m_valid_q;
    assign overrun     = overrun_q;
    assign frame_error = frame_error_q;
    assign byte_index  = byte_idx_q;

endmodule

// File: tb/tb_histo_deserializer.sv
// Directed plus randomized bench for histo_deserializer; expected words are built
// from the transmitted byte stream (byte 0 in bits 7:0, MSB sent first).
module tb_histo_deserializer;

    logic        fast_clk_in = 1'b0;
    logic        reset = 1'b1;
    logic        serial_clk_in = 1'b0;
    logic        serial_in = 1'b0;
    logic        resync = 1'b0;
    logic        clear_errors = 1'b0;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        overrun;
    logic        frame_error;
    logic [1:0]  byte_index;

    int total = 0;
    int bad   = 0;

    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];

    histo_deserializer #(.IDLE_TIMEOUT(256), .SYNC_STAGES(2)) dut (
        .fast_clk_in   (fast_clk_in),
        .reset         (reset),
        .serial_clk_in (serial_clk_in),
        .serial_in     (serial_in),
        .resync        (resync),
        .clear_errors  (clear_errors),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .overrun       (overrun),
        .frame_error   (frame_error),
        .byte_index    (byte_index)
    );

    always #5 fast_clk_in = ~fast_clk_in;

    // Every handshake the consumer completes.
    always @(negedge fast_clk_in) begin
        if (!reset && m_valid && m_ready) got_q.push_back(m_data);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge fast_clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits, input int half);
        for (int i = 7; i > 7 - nbits; i--) begin
            serial_in = b[i];
            tick(half);
            serial_clk_in = 1'b1;
            tick(half);
            serial_clk_in = 1'b0;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int half, input int gap);
        for (int k = 0; k < 4; k++) begin
            send_bits(8'(w >> (8 * k)), 8, half);
            tick(gap);
        end
    endtask

    // Compare accepted words with the expected list, then empty both.
    task automatic check_words(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check(tag, (i < got_q.size()) ? got_q[i] : 32'hxxxxxxxx, exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0]  bytes[4];
        logic [31:0] w;
        int          half, gap;

        // Reset state.
        tick(3);
        check("rst_m_data", m_data, 32'h0);
        check("rst_m_valid", 32'(m_valid), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_frame_error", 32'(frame_error), 32'h0);
        check("rst_byte_index", 32'(byte_index), 32'h0);
        reset = 1'b0;
        tick(300);

        // Single word from individual bytes, assembled LSB byte first.
        m_ready = 1'b1;
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
        for (int k = 0; k < 4; k++) send_bits(bytes[k], 8, 16);
        tick(12);
        exp_q.push_back(32'(bytes[0]) | (32'(bytes[1]) << 8) | (32'(bytes[2]) << 16) | (32'(bytes[3]) << 24));
        check_words("word1");
        check("word1_overrun", 32'(overrun), 32'h0);
        check("word1_frame_error", 32'(frame_error), 32'h0);
        check("word1_valid_low", 32'(m_valid), 32'h0);

        // Back-to-back words with inter-byte gaps.
        send_word(32'hDEADBEEF, 16, 40);
        send_word(32'h01234567, 16, 40);
        tick(12);
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'h01234567);
        check_words("b2b");
        check("b2b_byte_index", 32'(byte_index), 32'h0);

        // Overrun: second word dropped while the first is held.
        m_ready = 1'b0;
        send_word(32'hAAAA5555, 16, 0);
        tick(12);
        check("hold_valid", 32'(m_valid), 32'h1);
        check("hold_data", m_data, 32'hAAAA5555);
        send_word(32'h12345678, 16, 0);
        tick(12);
        check("ovr_data", m_data, 32'hAAAA5555);
        check("ovr_flag", 32'(overrun), 32'h1);
        m_ready = 1'b1;
        tick(1);
        m_ready = 1'b0;
        check("ovr_valid_drop", 32'(m_valid), 32'h0);
        exp_q.push_back(32'hAAAA5555);
        check_words("ovr_accept");
        clear_errors = 1'b1;
        tick(1);
        clear_errors = 1'b0;
        check("ovr_cleared", 32'(overrun), 32'h0);

        // Partial byte then timeout: framing error and clean realign.
        m_ready = 1'b1;
        send_bits(8'hA5, 5, 16);
        tick(300);
        check("tmo_frame_error", 32'(frame_error), 32'h1);
        check("tmo_byte_index", 32'(byte_index), 32'h0);
        send_word(32'hCAFEF00D, 16, 0);
        tick(12);
        check("tmo_data", m_data, 32'hCAFEF00D);
        exp_q.push_back(32'hCAFEF00D);
        check_words("tmo_word");

        // Two whole bytes then resync.
        clear_errors = 1'b1;
        tick(1);
        clear_errors = 1'b0;
        check("rsy_pre_clear", 32'(frame_error), 32'h0);
        send_bits(8'h77, 8, 16);
        send_bits(8'h88, 8, 16);
        tick(4);
        check("rsy_mid_index", 32'(byte_index), 32'h2);
        resync = 1'b1;
        tick(1);
        resync = 1'b0;
        check("rsy_frame_error", 32'(frame_error), 32'h1);
        check("rsy_byte_index", 32'(byte_index), 32'h0);
        send_word(32'h0F0F0F0F, 16, 0);
        tick(12);
        check("rsy_data", m_data, 32'h0F0F0F0F);
        exp_q.push_back(32'h0F0F0F0F);
        check_words("rsy_word");

        // Reset in the middle of a byte.
        send_bits(8'hFF, 3, 16);
        reset = 1'b1;
        tick(2);
        check("mid_rst_m_data", m_data, 32'h0);
        check("mid_rst_m_valid", 32'(m_valid), 32'h0);
        check("mid_rst_frame_error", 32'(frame_error), 32'h0);
        check("mid_rst_byte_index", 32'(byte_index), 32'h0);
        reset = 1'b0;
        got_q.delete();
        tick(4);
        send_word(32'h5A5AC3C3, 16, 0);
        tick(12);
        exp_q.push_back(32'h5A5AC3C3);
        check_words("post_rst");

        // Random words, half-bit periods and inter-byte gaps.
        for (int n = 0; n < 6; n++) begin
            w    = $urandom;
            half = int'($urandom_range(4, 12));
            gap  = int'($urandom_range(2, 100));
            send_word(w, half, gap);
            exp_q.push_back(w);
        end
        tick(20);
        check_words("rand");
        check("rand_overrun", 32'(overrun), 32'h0);
        check("rand_frame_error", 32'(frame_error), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
